// File: rtl/led_pattern_sched.sv
// Pattern scheduler for the 8+8 red/green LED scroll bars: it generates the tick,
// selects one of four pattern modes, and handles pause/step from push-buttons.
module led_pattern_sched #(
  parameter int TICK_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_pause,
  input  logic       btn_step,
  input  logic [1:0] speed,
  output logic [7:0] shift_red,
  output logic [7:0] shift_green,
  output logic [1:0] mode,
  output logic       paused,
  output logic       tick
);

  typedef enum logic [1:0] {
    M_SCROLL = 2'd0,
    M_BOUNCE = 2'd1,
    M_FILL   = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  // Button bit order: [0]=mode, [1]=pause, [2]=step
  logic [2:0] r_btn_s1;
  logic [2:0] r_btn_s2;
  logic [2:0] r_btn_prev;
  logic [2:0] w_btn_edge;
  logic       w_mode_edge;
  logic       w_pause_edge;
  logic       w_step_edge;

  mode_t                r_mode;
  mode_t                w_mode_next;
  logic [1:0]           w_mode_inc;
  logic                 r_paused;
  logic                 w_paused_next;
  logic                 r_tick;
  logic                 r_dir_right;
  logic                 w_dir_next;
  logic [7:0]           r_red;
  logic [7:0]           r_green;
  logic [7:0]           w_red_next;
  logic [7:0]           w_green_next;
  logic [TICK_BITS-1:0] r_cnt;
  logic [TICK_BITS-1:0] w_cnt_next;
  logic [TICK_BITS-1:0] w_cnt_mask;
  logic                 w_tick_en;
  logic                 w_advance;
  logic                 w_bounce_right;
  logic [7:0]           w_bounce_red;
  logic [7:0]           w_fill_red;
  logic [7:0]           w_fill_green;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_s1   <= {btn_step, btn_pause, btn_mode};
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= r_btn_s2;
    end
  end

  assign w_btn_edge   = r_btn_s2 & ~r_btn_prev;
  assign w_mode_edge  = w_btn_edge[0];
  assign w_pause_edge = w_btn_edge[1];
  assign w_step_edge  = w_btn_edge[2];

  // Tick fires when the low (TICK_BITS-speed) counter bits are all ones
  assign w_cnt_mask = {TICK_BITS{1'b1}} >> speed;
  assign w_tick_en  = &(r_cnt | ~w_cnt_mask);
  assign w_advance  = ~w_mode_edge & ((w_tick_en & ~r_paused) | (w_step_edge & r_paused));
  assign w_mode_inc = r_mode + 2'd1;

  // Turn-around happens on the move away from either end
  assign w_bounce_right = (r_red == 8'h80) ? 1'b1 :
                          (r_red == 8'h01) ? 1'b0 : r_dir_right;
  assign w_bounce_red   = w_bounce_right ? (r_red >> 1) : (r_red << 1);
  assign w_fill_red     = (r_red == 8'hFF) ? 8'h00 : {r_red[6:0], 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rev
      assign w_fill_green[gi] = w_fill_red[7-gi];
    end
  endgenerate

  always_comb begin
    w_mode_next   = r_mode;
    w_paused_next = r_paused ^ w_pause_edge;
    w_cnt_next    = r_paused ? r_cnt : r_cnt + {{(TICK_BITS-1){1'b0}}, 1'b1};
    w_dir_next    = r_dir_right;
    w_red_next    = r_red;
    w_green_next  = r_green;
    if (w_mode_edge) begin
      w_mode_next = mode_t'(w_mode_inc);
      w_cnt_next  = '0;
      w_dir_next  = 1'b0;
      case (w_mode_next)
        M_SCROLL: begin w_red_next = 8'h01; w_green_next = 8'h80; end
        M_BOUNCE: begin w_red_next = 8'h01; w_green_next = 8'hFE; end
        M_FILL:   begin w_red_next = 8'h00; w_green_next = 8'h00; end
        default:  begin w_red_next = 8'hFF; w_green_next = 8'h00; end
      endcase
    end else if (w_advance) begin
      case (r_mode)
        M_SCROLL: begin
          w_red_next   = {r_red[6:0], r_red[7]};
          w_green_next = {r_green[0], r_green[7:1]};
        end
        M_BOUNCE: begin
          w_dir_next   = w_bounce_right;
          w_red_next   = w_bounce_red;
          w_green_next = ~w_bounce_red;
        end
        M_FILL: begin
          w_red_next   = w_fill_red;
          w_green_next = w_fill_green;
        end
        default: begin
          w_red_next   = r_green;
          w_green_next = r_red;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode      <= M_SCROLL;
      r_paused    <= 1'b0;
      r_tick      <= 1'b0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
      r_red       <= 8'h01;
      r_green     <= 8'h80;
    end else begin
      r_mode      <= w_mode_next;
      r_paused    <= w_paused_next;
      r_tick      <= w_advance;
      r_cnt       <= w_cnt_next;
      r_dir_right <= w_dir_next;
      r_red       <= w_red_next;
      r_green     <= w_green_next;
    end
  end

  assign shift_red   = r_red;
  assign shift_green = r_green;
  assign mode        = r_mode;
  assign paused      = r_paused;
  assign tick        = r_tick;

endmodule
